// File: rtl/deint_pkg.sv
// rtl/deint_pkg.sv - shared packet-type constants, geometry width and sink state type
package deint_pkg;

    localparam logic [3:0] PKT_CTRL  = 4'hF;
    localparam logic [3:0] PKT_VIDEO = 4'h0;
    localparam int         GEOM_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CTRL,
        ST_VIDEO,
        ST_DRAIN
    } sink_state_t;

endpackage

// File: rtl/deint_field_sink_if.sv
// rtl/deint_field_sink_if.sv - Avalon-ST video input bundle for the field sink
interface deint_field_sink_if #(
    parameter int DATA_WIDTH = 24
);
    logic [DATA_WIDTH-1:0] din_data;
    logic                  din_valid;
    logic                  din_startofpacket;
    logic                  din_endofpacket;
    logic                  din_ready;

    modport master (
        output din_data, din_valid, din_startofpacket, din_endofpacket,
        input  din_ready
    );

    modport slave (
        input  din_data, din_valid, din_startofpacket, din_endofpacket,
        output din_ready
    );
endinterface

// File: rtl/deint_ctrl_parser.sv
// rtl/deint_ctrl_parser.sv - control-packet nibble shifter with geometry clamp
module deint_ctrl_parser
    import deint_pkg::*;
#(
    parameter int MAX_WIDTH = 1024,
    parameter int MAX_LINES = 512
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              beat_en_i,
    input  logic [3:0]        beat_idx_i,
    input  logic [3:0]        nibble_i,
    output logic [GEOM_W-1:0] width_o,
    output logic [GEOM_W-1:0] lines_o
);

    logic [GEOM_W-1:0] width_sh_q;
    logic [GEOM_W-1:0] lines_sh_q;

    // Zero or out-of-range geometry falls back to the buffer capacity.
    function automatic logic [GEOM_W-1:0] clamp(input logic [GEOM_W-1:0] v,
                                                 input int unsigned max_v);
        if (v == '0 || 32'(v) > max_v) begin
            return GEOM_W'(max_v);
        end
        return v;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            width_sh_q <= '0;
            lines_sh_q <= '0;
        end else if (beat_en_i) begin
            if (beat_idx_i < 4'd4) begin
                width_sh_q <= {width_sh_q[GEOM_W-5:0], nibble_i};
            end else if (beat_idx_i < 4'd8) begin
                lines_sh_q <= {lines_sh_q[GEOM_W-5:0], nibble_i};
            end
        end
    end

    assign width_o = clamp(width_sh_q, MAX_WIDTH);
    assign lines_o = clamp(lines_sh_q, MAX_LINES);

endmodule

// File: rtl/deint_field_sink.sv
// rtl/deint_field_sink.sv - round-robin line-buffer field sink; DEINT_SINK_CTRL_PARSE_EN enables geometry parsing
module deint_field_sink
    import deint_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int MAX_WIDTH  = 1024,
    parameter int MAX_LINES  = 512,
    parameter int NUM_BUFS   = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    deint_field_sink_if.slave            din,
    output logic [NUM_BUFS-1:0]          wr_req,
    output logic [$clog2(MAX_WIDTH)-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0]        wr_data,
    output logic                         line_done,
    output logic [$clog2(NUM_BUFS)-1:0]  line_buf,
    output logic [$clog2(MAX_LINES)-1:0] line_num,
    output logic                         field_done,
    input  logic                         line_release,
    output logic [GEOM_W-1:0]            act_width,
    output logic [GEOM_W-1:0]            act_lines,
    output logic                         err_short,
    output logic                         err_long
);

    localparam int AW = $clog2(MAX_WIDTH);
    localparam int LW = $clog2(MAX_LINES);
    localparam int BW = $clog2(NUM_BUFS);
    localparam int OW = $clog2(NUM_BUFS + 1);
`ifdef DEINT_SINK_CTRL_PARSE_EN
    localparam bit PARSE_EN = 1'b1;
`else
    localparam bit PARSE_EN = 1'b0;
`endif

    sink_state_t   state_q, state_d;
    logic [AW-1:0] px_q;
    logic [LW-1:0] line_q;
    logic [BW-1:0] wr_ptr_q, rd_ptr_q;
    logic [OW-1:0] occ_q, occ_d;
    logic          ready_q, ready_d;
    logic          from_video_q;
    logic          line_done_q, field_done_q;
    logic [BW-1:0] line_buf_q;
    logic [LW-1:0] line_num_q;
    logic          err_short_q, err_long_q;

    logic       xfer, sop, eop, video_sop, video_beat;
    logic       px_last, line_last, line_cmp, rel;
    logic [3:0] nib;

    function automatic logic [BW-1:0] ptr_inc(input logic [BW-1:0] p);
        return (p == BW'(NUM_BUFS - 1)) ? '0 : p + BW'(1);
    endfunction

    assign xfer       = din.din_valid & ready_q;
    assign sop        = din.din_startofpacket;
    assign eop        = din.din_endofpacket;
    assign nib        = din.din_data[3:0];
    assign video_sop  = xfer && sop && (state_q == ST_IDLE) && (nib == PKT_VIDEO);
    assign video_beat = xfer && (state_q == ST_VIDEO);
    assign px_last    = (GEOM_W'(px_q) == act_width - GEOM_W'(1));
    assign line_last  = (GEOM_W'(line_q) == act_lines - GEOM_W'(1));
    assign line_cmp   = video_beat && px_last;
    assign rel        = line_release && (occ_q != '0);

`ifdef DEINT_SINK_CTRL_PARSE_EN
    logic [3:0]        ctrl_cnt_q;
    logic [GEOM_W-1:0] parsed_width, parsed_lines;
    logic [GEOM_W-1:0] act_width_q, act_lines_q;

    deint_ctrl_parser #(
        .MAX_WIDTH(MAX_WIDTH),
        .MAX_LINES(MAX_LINES)
    ) u_parser (
        .clock      (clock),
        .reset      (reset),
        .beat_en_i  (xfer && (state_q == ST_CTRL)),
        .beat_idx_i (ctrl_cnt_q),
        .nibble_i   (nib),
        .width_o    (parsed_width),
        .lines_o    (parsed_lines)
    );

    // Parsed geometry is only adopted at a video header so a field never changes shape.
    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl_cnt_q  <= '0;
            act_width_q <= GEOM_W'(MAX_WIDTH);
            act_lines_q <= GEOM_W'(MAX_LINES);
        end else begin
            if (state_q == ST_IDLE) begin
                ctrl_cnt_q <= '0;
            end else if (xfer && state_q == ST_CTRL && ctrl_cnt_q != 4'hF) begin
                ctrl_cnt_q <= ctrl_cnt_q + 4'd1;
            end
            if (video_sop) begin
                act_width_q <= parsed_width;
                act_lines_q <= parsed_lines;
            end
        end
    end

    assign act_width = act_width_q;
    assign act_lines = act_lines_q;
`else
    assign act_width = GEOM_W'(MAX_WIDTH);
    assign act_lines = GEOM_W'(MAX_LINES);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer && sop && !eop) begin
                    if (nib == PKT_VIDEO) begin
                        state_d = ST_VIDEO;
                    end else if (nib == PKT_CTRL && PARSE_EN) begin
                        state_d = ST_CTRL;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_VIDEO: begin
                if (line_cmp && line_last) begin
                    state_d = eop ? ST_IDLE : ST_DRAIN;
                end else if (video_beat && eop) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CTRL, ST_DRAIN: begin
                if (xfer && eop) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_req  = '0;
        wr_addr = px_q;
        if (video_beat) begin
            wr_req[wr_ptr_q] = 1'b1;
        end
    end

    assign wr_data = din.din_data;

    // Completion and release in the same cycle cancel in the count but both pointers move.
    always_comb begin
        occ_d   = occ_q + OW'(line_cmp) - OW'(rel);
        ready_d = (state_d != ST_VIDEO) || (occ_d < OW'(NUM_BUFS));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            px_q         <= '0;
            line_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            ready_q      <= 1'b0;
            from_video_q <= 1'b0;
            line_done_q  <= 1'b0;
            field_done_q <= 1'b0;
            line_buf_q   <= '0;
            line_num_q   <= '0;
            err_short_q  <= 1'b0;
            err_long_q   <= 1'b0;
        end else begin
            occ_q        <= occ_d;
            ready_q      <= ready_d;
            line_done_q  <= line_cmp;
            field_done_q <= line_cmp && line_last;
            if (line_cmp) begin
                line_buf_q <= wr_ptr_q;
                line_num_q <= line_q;
            end
            if (rel) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (video_sop) begin
                px_q   <= '0;
                line_q <= '0;
            end else if (video_beat) begin
                if (px_last) begin
                    px_q     <= '0;
                    line_q   <= line_q + LW'(1);
                    wr_ptr_q <= ptr_inc(wr_ptr_q);
                end else begin
                    px_q <= px_q + AW'(1);
                end
            end
            if (state_q == ST_VIDEO) begin
                from_video_q <= 1'b1;
            end else if (state_q == ST_IDLE) begin
                from_video_q <= 1'b0;
            end
            if ((video_beat && eop && !(line_cmp && line_last)) || (video_sop && eop)) begin
                err_short_q <= 1'b1;
            end
            if (xfer && state_q == ST_DRAIN && from_video_q) begin
                err_long_q <= 1'b1;
            end
        end
    end

    assign din.din_ready = ready_q;
    assign line_done     = line_done_q;
    assign line_buf      = line_buf_q;
    assign line_num      = line_num_q;
    assign field_done    = field_done_q;
    assign err_short     = err_short_q;
    assign err_long      = err_long_q;

endmodule

// File: tb/tb_deint_field_sink.sv
// tb/tb_deint_field_sink.sv - directed table-driven bench for deint_field_sink
module tb_deint_field_sink;
    localparam int DW = 24;
    localparam int MW = 8;
    localparam int ML = 4;
    localparam int NB = 2;
`ifdef DEINT_SINK_CTRL_PARSE_EN
    localparam int EW = 4;
    localparam int EL = 3;
`else
    localparam int EW = 8;
    localparam int EL = 4;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    deint_field_sink_if #(.DATA_WIDTH(DW)) din_if();

    logic [NB-1:0] wr_req;
    logic [2:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic          line_done;
    logic [0:0]    line_buf;
    logic [1:0]    line_num;
    logic          field_done;
    logic          line_release;
    logic [15:0]   act_width, act_lines;
    logic          err_short, err_long;

    logic man_rel = 1'b0;
    logic auto_rel = 1'b0;
    assign line_release = man_rel | (auto_rel & line_done);

    int checks = 0;
    int errors = 0;
    int bad_wr = 0;
    int mptr = 0;
    logic [3:0] ld_q[$];

    typedef struct {
        logic [23:0] data;
        bit          eop;
        logic [1:0]  exp_req;
        logic [2:0]  exp_addr;
    } vec_t;
    vec_t tbl[EW*EL];

    deint_field_sink #(
        .DATA_WIDTH(DW), .MAX_WIDTH(MW), .MAX_LINES(ML), .NUM_BUFS(NB)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .din          (din_if),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .line_done    (line_done),
        .line_buf     (line_buf),
        .line_num     (line_num),
        .field_done   (field_done),
        .line_release (line_release),
        .act_width    (act_width),
        .act_lines    (act_lines),
        .err_short    (err_short),
        .err_long     (err_long)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && line_done) ld_q.push_back({field_done, line_buf, line_num});
        if (wr_req != '0) begin
            if (!din_if.din_ready) bad_wr++;
            chk("wr_data", 32'(wr_data), 32'(din_if.din_data));
        end
    end

    // Called #1 after a rising edge; returns #1 after the edge that transfers the beat.
    task automatic send(input logic [23:0] d, input bit s, input bit e,
                        output logic [1:0] req, output logic [2:0] addr, output int stalls);
        stalls = 0;
        din_if.din_data = d;
        din_if.din_startofpacket = s;
        din_if.din_endofpacket = e;
        din_if.din_valid = 1'b1;
        @(negedge clock);
        while (!din_if.din_ready && stalls < 50) begin
            stalls++;
            @(negedge clock);
        end
        if (!din_if.din_ready) chk("send_timeout", 32'(stalls), 32'd0);
        req = wr_req;
        addr = wr_addr;
        @(posedge clock);
        #1;
        din_if.din_valid = 1'b0;
        din_if.din_startofpacket = 1'b0;
        din_if.din_endofpacket = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check_lines(input int n, input int p0, input bit fd_last);
        logic [3:0] e, x;
        chk("line_count", 32'(ld_q.size()), 32'(n));
        for (int j = 0; j < n && ld_q.size() > 0; j++) begin
            e = ld_q.pop_front();
            x = {fd_last && (j == n - 1), 1'((p0 + j) % 2), 2'(j)};
            chk("line_event", 32'(e), 32'(x));
        end
        ld_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0] r;
        logic [2:0] a;
        int st, p;
        logic [3:0] cn[9];

        cn = '{4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h3, 4'h0};
        din_if.din_valid = 1'b0;
        din_if.din_startofpacket = 1'b0;
        din_if.din_endofpacket = 1'b0;
        din_if.din_data = '0;
        for (int i = 0; i < EW*EL; i++) begin
            tbl[i].data = 24'hA00000 + 24'(i);
            tbl[i].eop = (i == EW*EL - 1);
            tbl[i].exp_req = 2'b01 << ((i / EW) % 2);
            tbl[i].exp_addr = 3'(i % EW);
        end

        // Reset state
        idle(3);
        @(negedge clock);
        chk("rst_ready", 32'(din_if.din_ready), 0);
        chk("rst_wr_req", 32'(wr_req), 0);
        chk("rst_line_done", 32'(line_done), 0);
        chk("rst_field_done", 32'(field_done), 0);
        chk("rst_errs", 32'({err_short, err_long}), 0);
        chk("rst_act_width", 32'(act_width), MW);
        chk("rst_act_lines", 32'(act_lines), ML);
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle(1);
        chk("ready_after_reset", 32'(din_if.din_ready), 1);

        // Control packet then a full field with immediate release
        auto_rel = 1'b1;
        send(24'h00000F, 1, 0, r, a, st);
        for (int k = 0; k < 9; k++) send({20'h0, cn[k]}, 0, k == 8, r, a, st);
        chk("act_width_before_video", 32'(act_width), MW);
        send(24'h000000, 1, 0, r, a, st);
        chk("act_width", 32'(act_width), EW);
        chk("act_lines", 32'(act_lines), EL);
        for (int i = 0; i < EW*EL; i++) begin
            send(tbl[i].data, 0, tbl[i].eop, r, a, st);
            chk("tbl_req", 32'(r), 32'(tbl[i].exp_req));
            chk("tbl_addr", 32'(a), 32'(tbl[i].exp_addr));
        end
        idle(3);
        check_lines(EL, 0, 1);
        chk("field_err_short", 32'(err_short), 0);
        chk("field_err_long", 32'(err_long), 0);
        mptr = EL % 2;

        // Both buffers full: stall until one release
        p = mptr;
        auto_rel = 1'b0;
        send(24'h000000, 1, 0, r, a, st);
        for (int i = 0; i < 2*EW; i++) send(24'(i), 0, 0, r, a, st);
        @(negedge clock);
        chk("ready_low_after_fill", 32'(din_if.din_ready), 0);
        din_if.din_data = 24'h5A5A00;
        din_if.din_valid = 1'b1;
        repeat (3) @(negedge clock);
        chk("ready_still_low", 32'(din_if.din_ready), 0);
        @(posedge clock);
        #1;
        man_rel = 1'b1;
        @(posedge clock);
        #1;
        man_rel = 1'b0;
        @(negedge clock);
        chk("ready_after_release", 32'(din_if.din_ready), 1);
        chk("resume_req", 32'(wr_req), 32'(2'b01 << p));
        chk("resume_addr", 32'(wr_addr), 0);
        @(posedge clock);
        #1;
        din_if.din_valid = 1'b0;
        @(posedge clock);
        #1;
        man_rel = 1'b1;
        @(posedge clock);
        #1;
        man_rel = 1'b0;
        auto_rel = 1'b1;
        for (int i = 2*EW + 1; i < EW*EL; i++) send(24'(i), 0, i == EW*EL - 1, r, a, st);
        idle(3);
        check_lines(EL, p, 1);
        mptr = (p + EL) % 2;

        // Completion and release in the same cycle with one buffer occupied
        p = mptr;
        auto_rel = 1'b0;
        send(24'h000000, 1, 0, r, a, st);
        for (int i = 0; i < 2*EW - 1; i++) send(24'(i), 0, 0, r, a, st);
        man_rel = 1'b1;
        send(24'(2*EW - 1), 0, 0, r, a, st);
        man_rel = 1'b0;
        @(negedge clock);
        chk("simul_ready_high", 32'(din_if.din_ready), 1);
        chk("simul_line_done", 32'(line_done), 1);
        @(posedge clock);
        #1;
        man_rel = 1'b1;
        @(posedge clock);
        #1;
        man_rel = 1'b0;
        auto_rel = 1'b1;
        for (int i = 2*EW; i < EW*EL; i++) send(24'(i), 0, i == EW*EL - 1, r, a, st);
        idle(3);
        check_lines(EL, p, 1);
        mptr = (p + EL) % 2;

        // Short video packet
        p = mptr;
        send(24'h000000, 1, 0, r, a, st);
        for (int i = 0; i < EW + 2; i++) send(24'(i), 0, i == EW + 1, r, a, st);
        idle(3);
        check_lines(1, p, 0);
        chk("short_err_short", 32'(err_short), 1);
        chk("short_err_long", 32'(err_long), 0);
        chk("short_ready", 32'(din_if.din_ready), 1);
        mptr = (p + 1) % 2;
        send(24'h000003, 1, 0, r, a, st);
        chk("other_sop_stalls", 32'(st), 0);
        send(24'h000005, 0, 1, r, a, st);
        chk("other_wr_req", 32'(r), 0);
        idle(2);
        chk("idle_drain_err_long", 32'(err_long), 0);

        // Long video packet
        p = mptr;
        send(24'h000000, 1, 0, r, a, st);
        for (int i = 0; i < EW*EL + 2; i++) begin
            send(24'(i), 0, i == EW*EL + 1, r, a, st);
            if (i >= EW*EL) begin
                chk("drain_stalls", 32'(st), 0);
                chk("drain_no_wr", 32'(r), 0);
            end
        end
        idle(3);
        check_lines(EL, p, 1);
        chk("long_err_long", 32'(err_long), 1);
        chk("no_write_while_stalled", 32'(bad_wr), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/deint_field_sink.md
# deint_field_sink

Parametrised Avalon-ST video field sink for the deinterlacer. Parses control packets for geometry, then writes each video line into one of NUM_BUFS line buffers in round-robin order. It tracks buffer occupancy against a per-line release handshake from the output stage and back-pressures the upstream source when every buffer holds an unconsumed line. It sits between the video input and the line buffers / averaging source, and generalises the fixed two-buffer, fixed-geometry sink.

## Interface
- DATA_WIDTH, 24: pixel beat width.
- MAX_WIDTH, 1024: maximum pixels per line. Line-buffer depth.
- MAX_LINES, 512: maximum lines per field packet.
- NUM_BUFS, 2: line buffers, ≥2.
- clock  in  1  single clock; all logic rising-edge.
- reset  in  1  synchronous, active-high.
- din_data  in  DATA_WIDTH  Avalon-ST data.
- din_valid / din_startofpacket / din_endofpacket  in  1 each  Avalon-ST qualifiers.
- din_ready  out  1  registered ready. A beat transfers when din_valid & din_ready.
- wr_req  out  NUM_BUFS  one-hot write strobe to line buffer k.
- wr_addr  out  $clog2(MAX_WIDTH)  pixel index within line.
- wr_data  out  DATA_WIDTH  equals din_data.
- line_done  out  1  one-cycle pulse: a full line has been written.
- line_buf  out  $clog2(NUM_BUFS)  buffer holding that line. Valid with line_done.
- line_num  out  $clog2(MAX_LINES)  index of that line. Valid with line_done.
- field_done  out  1  pulse coincident with line_done of the last line.
- line_release  in  1  pulse: consumer frees the oldest full buffer.
- act_width / act_lines  out  16 each  geometry in use.
- err_short / err_long  out  1 each  sticky: packet ended early / carried extra beats. Cleared by reset only.

## Operation
- States:
  - IDLE: wait for a transfer with sop. Low nibble of din_data[3:0] selects the next state:
    - 4'hF → CTRL
    - 4'h0 → VIDEO, with px=0, line=0
    - other → DRAIN
  - CTRL: one nibble per beat from din_data[3:0], MSB first. Beats 0–3 carry width, 4–7 carry lines, beat 8 is ignored. Go to IDLE on eop.
  - VIDEO:
    - Each transfer drives wr_req[wr_ptr]=1, wr_addr=px, then px++.
    - At px==act_width-1: px←0, mark buffer wr_ptr full, wr_ptr←(wr_ptr+1) mod NUM_BUFS, line++.
    - Completion of line act_lines-1 → DRAIN, or → IDLE if that beat carried eop.
    - eop before the last pixel of the last line: set err_short, discard the partial line (no line_done), → IDLE.
  - DRAIN: accept and discard beats. Set err_long if entered from VIDEO and at least one further beat arrives. Go to IDLE on eop.
- Occupancy:
  - occ counter, width $clog2(NUM_BUFS+1), plus rd_ptr.
  - Line completion increments occ. line_release with occ>0 decrements occ and advances rd_ptr.
  - line_release with occ==0 is ignored.
  - Simultaneous completion and release: occ unchanged, both pointers advance.
- din_ready:
  - Registered. Loaded with the next-cycle condition: state≠VIDEO, or next occ<NUM_BUFS.
  - A beat is never accepted into a full buffer. No beat is lost or duplicated across stalls.
- Geometry:
  - A parsed value of 0 or >MAX selects the parameter maximum.
  - The new geometry takes effect at the next video sop, never mid-packet.
  - Buffers are not pre-cleared between fields.

## Timing
- wr_req, wr_addr, wr_data: combinational from the transfer in the same cycle (zero latency).
- line_done, line_buf, line_num, field_done: registered, asserted the cycle after the last pixel transfer.
- din_ready falls the cycle after the transfer that fills the last free buffer. It rises the cycle after the line_release that frees one.
- Reset values:
  - din_ready=0, wr_req=0, line_done=0, field_done=0, err_*=0.
  - act_width=MAX_WIDTH, act_lines=MAX_LINES.
  - occ=0, wr_ptr=rd_ptr=0, state=IDLE.
- din_ready=1 on the first cycle after reset deasserts.
- Reset mid-packet discards everything. Upstream must restart at a sop.

## Configuration
- DEINT_SINK_CTRL_PARSE_EN:
  - Defined: CTRL parses geometry as above.
  - Undefined: control packets are drained unparsed; act_width/act_lines are tied to MAX_WIDTH/MAX_LINES.

## Structure
- Shared package deint_pkg holds:
  - packet-type constants PKT_CTRL=4'hF and PKT_VIDEO=4'h0
  - the state enum typedef sink_state_t
  - the geometry width constant GEOM_W=16
- Sub-module deint_ctrl_parser is natural: it holds the nibble shift and geometry clamp, and is instantiated only under DEINT_SINK_CTRL_PARSE_EN.

## Test plan
All scenarios use MAX_WIDTH=8, MAX_LINES=4, NUM_BUFS=2, with DEINT_SINK_CTRL_PARSE_EN defined unless stated.

- Ctrl packet (width 4, lines 3), video packet of 12 beats, consumer releases each line at once → line_done ×3 on buffers 0,1,0; field_done with line_num=2; no errors.
- Same, no release until the second line completes → din_ready low one cycle after beat 8, no wr_req while low; one release → ready back next cycle, beat 9 written to buffer 0 at addr 0.
- line_done and line_release in the same cycle with occ=1 → occ stays 1, din_ready stays high.
- Video packet eop after 6 beats (width 4) → line_done once, err_short=1, state IDLE, next sop accepted.
- Video packet of 14 beats (width 4, lines 3) → extra 2 beats drained with ready high, err_long=1.
- Macro undefined, ctrl packet width 4 → drained; video uses width 8: line_done after 8 beats.
